// File: rtl/polytomsg_ctrl.sv
// Kyber poly-to-message sequencer: reads 256 coefficients, decodes one bit each,
// and streams 32 packed message bytes over a valid/ready byte interface.
module polytomsg_ctrl #(
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int i_Width = 12,
  parameter int o_Width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iStart,
  output logic               oBusy,
  output logic               oDone,
  output logic               oPolyRdEn,
  output logic [7:0]         oPolyAddr,
  input  logic [i_Width-1:0] iPolyCoeff,
  output logic [7:0]         oMsgByte,
  output logic [4:0]         oMsgIdx,
  output logic               oMsgValid,
  input  logic               iMsgReady
);

  localparam logic [o_Width-1:0] HALF_Q    = o_Width'(KYBER_Q / 2);
  localparam logic [o_Width-1:0] Q_W       = o_Width'(KYBER_Q);
  localparam logic [o_Width-1:0] TWO_Q     = o_Width'(2 * KYBER_Q);
  localparam logic [4:0]         LAST_BYTE = 5'(KYBER_N / 8 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, PUSH, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [2:0]         bit_cnt;
  logic [4:0]         byte_cnt;
  logic [7:0]         shreg;
  logic [o_Width-1:0] t_val;
  logic               coeff_bit;
  logic               capture;
  logic               push_load;
  logic               last_byte;

  // Max t is below 3Q, so bit = floor(t/Q) & 1 reduces to a window compare.
  assign t_val     = (o_Width'(iPolyCoeff) << 1) + HALF_Q;
  assign coeff_bit = (t_val >= Q_W) && (t_val < TWO_Q);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign oPolyAddr = {byte_cnt, bit_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    oBusy      = (state != IDLE);
    oDone      = 1'b0;
    oPolyRdEn  = 1'b0;
    capture    = 1'b0;
    push_load  = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) next_state = FETCH;
      end
      FETCH: begin
        oPolyRdEn = 1'b1;
        capture   = (bit_cnt != 3'd0);
        if (bit_cnt == 3'd7) next_state = LAST;
      end
      LAST: begin
        capture    = 1'b1;
        next_state = PUSH;
      end
      PUSH: begin
        if (!oMsgValid || iMsgReady) begin
          push_load  = 1'b1;
          next_state = last_byte ? DONE : FETCH;
        end
      end
      DONE: begin
        oDone      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so each capture belongs to the
  // previously issued address; new bits enter at bit 7 to pack LSB-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      byte_cnt  <= 5'd0;
      shreg     <= 8'd0;
      oMsgByte  <= 8'd0;
      oMsgIdx   <= 5'd0;
      oMsgValid <= 1'b0;
    end else begin
      if (state == IDLE && iStart) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 5'd0;
      end
      if (oPolyRdEn) bit_cnt <= bit_cnt + 3'd1;
      if (capture) shreg <= {coeff_bit, shreg[7:1]};
      if (push_load && !last_byte) byte_cnt <= byte_cnt + 5'd1;
      if (push_load) begin
        oMsgByte  <= shreg;
        oMsgIdx   <= byte_cnt;
        oMsgValid <= 1'b1;
      end else if (oMsgValid && iMsgReady) begin
        oMsgValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_polytomsg_ctrl.sv
// Self-checking bench for polytomsg_ctrl: table-driven byte patterns, timed full runs,
// backpressure, start/reset corner cases and randomized data/ready against a model.
module tb_polytomsg_ctrl;

  logic        clk;
  logic        rst;
  logic        iStart;
  logic        oBusy;
  logic        oDone;
  logic        oPolyRdEn;
  logic [7:0]  oPolyAddr;
  logic [11:0] iPolyCoeff;
  logic [7:0]  oMsgByte;
  logic [4:0]  oMsgIdx;
  logic        oMsgValid;
  logic        iMsgReady;

  polytomsg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .iStart     (iStart),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oPolyRdEn  (oPolyRdEn),
    .oPolyAddr  (oPolyAddr),
    .iPolyCoeff (iPolyCoeff),
    .oMsgByte   (oMsgByte),
    .oMsgIdx    (oMsgIdx),
    .oMsgValid  (oMsgValid),
    .iMsgReady  (iMsgReady)
  );

  typedef struct packed {
    logic [7:0][11:0] coeffs;
    logic [7:0]       expected;
  } vec_t;

  vec_t        vecs [6];
  logic [11:0] mem [256];
  logic [11:0] rd_data;
  logic [12:0] got_q [$];
  logic [12:0] exp_q [$];
  logic [7:0]  addr_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          done_rel = -1;
  int          first_valid_rel = -1;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b0;
  logic [12:0] prev_word = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Poly RAM with one-cycle read latency
  always @(posedge clk) begin
    if (oPolyRdEn) rd_data <= mem[oPolyAddr];
  end
  assign iPolyCoeff = rd_data;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic ready);
    @(posedge clk);
    #1;
    iStart    = start;
    iMsgReady = ready;
  endtask

  // Mid-cycle monitor: records transfers, addresses, done pulses and held data
  always @(negedge clk) begin
    if (prev_stall && !prev_rst)
      checkOutput("hold_stable", int'({oMsgValid, oMsgIdx, oMsgByte}), int'({1'b1, prev_word}));
    if (oMsgValid && iMsgReady) got_q.push_back({oMsgIdx, oMsgByte});
    if (oMsgValid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
    if (oPolyRdEn) addr_q.push_back(oPolyAddr);
    if (oDone) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
    prev_stall = oMsgValid && !iMsgReady;
    prev_word  = {oMsgIdx, oMsgByte};
    prev_rst   = rst;
  end

  function automatic logic [7:0] model_byte(input int i);
    logic [7:0] r;
    int x, t;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      x = int'(mem[8*i + j]);
      t = 2*x + 1664;
      r[j] = ((t / 3329) % 2) == 1;
    end
    return r;
  endfunction

  function automatic int addr_errors();
    int e = 0;
    foreach (addr_q[k]) if (int'(addr_q[k]) != (k % 256)) e++;
    return e;
  endfunction

  task automatic build_exp_model(input int first);
    logic [4:0] idx;
    for (int i = first; i < 32; i++) begin
      idx = 5'(i);
      exp_q.push_back({idx, model_byte(i)});
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 256; k++) mem[k] = 12'($urandom_range(0, 4095));
  endtask

  task automatic clear_run();
    got_q.delete();
    exp_q.delete();
    addr_q.delete();
    first_valid_rel = -1;
    done_rel = -1;
  endtask

  task automatic start_run(input int hold);
    for (int h = 0; h < hold; h++) begin
      applyStimulus(1'b1, iMsgReady);
      if (h == 0) start_cyc = cyc;
    end
    applyStimulus(1'b0, iMsgReady);
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == prev) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic finish_and_check(input string name, input bit timing, input int prev,
                                  input int exp_addrs);
    int n = 0;
    logic [12:0] g, e;
    wait_done(prev);
    while (got_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      checkOutput($sformatf("%s_byte%0d", name, i), int'(g), int'(e));
    end
    checkOutput({name, "_addr_count"}, addr_q.size(), exp_addrs);
    checkOutput({name, "_addr_seq"}, addr_errors(), 0);
    checkOutput({name, "_done_pulses"}, done_cnt - prev, 1);
    checkOutput({name, "_idle_busy"}, int'(oBusy), 0);
    if (timing) begin
      checkOutput({name, "_first_valid_cycle"}, first_valid_rel, 11);
      checkOutput({name, "_done_cycle"}, done_rel, 321);
    end
  endtask

  initial begin
    int prev;
    int n;
    logic [12:0] e0;
    logic [4:0]  idx;

    rst       = 1'b1;
    iStart    = 1'b0;
    iMsgReady = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = '0;

    vecs[0] = '{coeffs: {12'd4095, 12'd1664, 12'd3328, 12'd0, 12'd2497, 12'd2496, 12'd833, 12'd832},
                expected: 8'h46};
    vecs[1] = '{coeffs: {8{12'd1664}}, expected: 8'hFF};
    vecs[2] = '{coeffs: {8{12'd0}}, expected: 8'h00};
    vecs[3] = '{coeffs: {12'd1664, 12'd0, 12'd1664, 12'd0, 12'd1664, 12'd0, 12'd1664, 12'd0},
                expected: 8'hAA};
    vecs[4] = '{coeffs: {12'd0, 12'd1664, 12'd0, 12'd1664, 12'd0, 12'd1664, 12'd0, 12'd1664},
                expected: 8'h55};
    vecs[5] = '{coeffs: {12'd832, 12'd832, 12'd832, 12'd832, 12'd833, 12'd833, 12'd833, 12'd833},
                expected: 8'h0F};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(oBusy), 0);
    checkOutput("reset_done", int'(oDone), 0);
    checkOutput("reset_rden", int'(oPolyRdEn), 0);
    checkOutput("reset_addr", int'(oPolyAddr), 0);
    checkOutput("reset_valid", int'(oMsgValid), 0);
    checkOutput("reset_byte", int'(oMsgByte), 0);
    checkOutput("reset_idx", int'(oMsgIdx), 0);
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b1);

    for (int v = 0; v < 6; v++) begin
      clear_run();
      fill_random();
      for (int j = 0; j < 8; j++) mem[j] = vecs[v].coeffs[j];
      exp_q.push_back({5'd0, vecs[v].expected});
      build_exp_model(1);
      prev = done_cnt;
      start_run(1);
      finish_and_check($sformatf("vec%0d", v), 1'b1, prev, 256);
    end

    // Alternating pattern: every byte is 0xAA
    clear_run();
    for (int k = 0; k < 256; k++) mem[k] = (k % 2 == 1) ? 12'd1664 : 12'd0;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      exp_q.push_back({idx, 8'hAA});
    end
    prev = done_cnt;
    start_run(1);
    finish_and_check("alt", 1'b1, prev, 256);

    // Backpressure on byte 0 for 50 cycles
    clear_run();
    fill_random();
    build_exp_model(0);
    iMsgReady = 1'b0;
    prev = done_cnt;
    start_run(1);
    n = 0;
    while (!oMsgValid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_valid_seen", int'(oMsgValid), 1);
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    e0 = exp_q[0];
    checkOutput("bp_no_transfer", got_q.size(), 0);
    checkOutput("bp_idx_held", int'(oMsgIdx), 0);
    checkOutput("bp_byte_held", int'(oMsgByte), int'(e0[7:0]));
    checkOutput("bp_addrs_stalled", addr_q.size(), 16);
    checkOutput("bp_no_rden", int'(oPolyRdEn), 0);
    iMsgReady = 1'b1;
    finish_and_check("bp", 1'b0, prev, 256);

    // Start held for 3 cycles, then a stray pulse while busy
    clear_run();
    fill_random();
    build_exp_model(0);
    prev = done_cnt;
    start_run(3);
    repeat (100) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    finish_and_check("start", 1'b1, prev, 256);
    repeat (40) applyStimulus(1'b0, 1'b1);
    checkOutput("start_no_rerun_addrs", addr_q.size(), 256);
    checkOutput("start_no_rerun_done", done_cnt - prev, 1);

    // Reset in the middle of byte 12
    clear_run();
    fill_random();
    prev = done_cnt;
    start_run(1);
    n = 0;
    while (!(oPolyRdEn && oPolyAddr[7:3] == 5'd12) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rst_reached_byte12", int'(oPolyAddr[7:3]), 12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_busy", int'(oBusy), 0);
    checkOutput("rst_valid", int'(oMsgValid), 0);
    checkOutput("rst_rden", int'(oPolyRdEn), 0);
    checkOutput("rst_done", int'(oDone), 0);
    rst = 1'b0;
    checkOutput("rst_no_done_pulse", done_cnt - prev, 0);
    repeat (3) applyStimulus(1'b0, 1'b1);
    clear_run();
    fill_random();
    build_exp_model(0);
    prev = done_cnt;
    start_run(1);
    finish_and_check("rst_rerun", 1'b1, prev, 256);

    // Back-to-back: run 1 byte 31 pending when run 2 starts
    clear_run();
    fill_random();
    build_exp_model(0);
    iMsgReady = 1'b1;
    prev = done_cnt;
    start_run(1);
    n = 0;
    while (got_q.size() < 31 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    iMsgReady = 1'b0;
    wait_done(prev);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("b2b_pending_valid", int'(oMsgValid), 1);
    checkOutput("b2b_pending_idx", int'(oMsgIdx), 31);
    checkOutput("b2b_idle_busy", int'(oBusy), 0);
    for (int k = 0; k < 256; k++) mem[k] = (k % 2 == 1) ? 12'd1664 : 12'd0;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      exp_q.push_back({idx, 8'hAA});
    end
    prev = done_cnt;
    start_run(1);
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    checkOutput("b2b_stall_addrs", addr_q.size(), 264);
    checkOutput("b2b_stall_rden", int'(oPolyRdEn), 0);
    checkOutput("b2b_stall_idx", int'(oMsgIdx), 31);
    checkOutput("b2b_stall_got", got_q.size(), 31);
    iMsgReady = 1'b1;
    finish_and_check("b2b", 1'b0, prev, 512);

    // Random data with random sink readiness
    for (int r = 0; r < 3; r++) begin
      clear_run();
      fill_random();
      build_exp_model(0);
      prev = done_cnt;
      start_run(1);
      n = 0;
      while (got_q.size() < 32 && n < 3000) begin
        @(posedge clk);
        #1;
        iMsgReady = ($urandom_range(0, 3) != 0);
        n++;
      end
      iMsgReady = 1'b1;
      finish_and_check($sformatf("rand%0d", r), 1'b0, prev, 256);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/polytomsg_ctrl.md
Name: polytomsg_ctrl

Overview:
- Sequencer for the Kyber poly-to-message step (decryption).
- Reads 256 reduced coefficients from a poly RAM with 1-cycle read latency.
- Computes t = (x<<1) + KYBER_Q/2 and derives each message bit as (t / KYBER_Q) & 1.
- Packs the bits LSB-first into 32 bytes and streams them out over a valid/ready byte interface towards the message buffer / hash stage.

Parameters:
- KYBER_N, 256, coefficients per polynomial; must be a multiple of 8.
- KYBER_Q, 3329, modulus.
- i_Width, 12, coefficient width.
- o_Width, 16, width of intermediate t.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- iStart, in, 1, start pulse; sampled only in IDLE.
- oBusy, out, 1, high from the cycle after iStart is accepted until DONE is left.
- oDone, out, 1, single-cycle pulse after byte 31 is handed off.
- oPolyRdEn, out, 1, RAM read enable.
- oPolyAddr, out, 8, RAM read address.
- iPolyCoeff, in, 12, RAM read data; valid the cycle after oPolyRdEn.
- oMsgByte, out, 8, message byte.
- oMsgIdx, out, 5, index of oMsgByte (0..31).
- oMsgValid, out, 1, oMsgByte/oMsgIdx valid.
- iMsgReady, in, 1, sink accepts; a transfer occurs when oMsgValid && iMsgReady.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high; it clears all state, returns the FSM to IDLE and has priority over all other inputs.
- Reset values: all outputs 0; internal bit counter, byte counter and shift register 0.
- Bit rule, in 16-bit arithmetic:
  - t = {4'h0,x}<<1 + KYBER_Q/2 (1664).
  - bit = 1 iff KYBER_Q <= t < 2*KYBER_Q, i.e. 833 <= x <= 2496.
  - This holds for every 12-bit x, including unreduced x >= KYBER_Q (max t = 9854 < 3Q), so no divider is required.
- Packing: bit j of byte i comes from coefficient 8i+j. Bit 0 is the LSB, so the shift register shifts right with the new bit entering at bit 7.
- FSM states: IDLE, FETCH, LAST, PUSH, DONE.
  - IDLE:
    - oBusy=0, oPolyRdEn=0.
    - iStart=1 -> FETCH with byte counter=0 and bit counter=0.
    - iStart in any other state is ignored.
  - FETCH (8 cycles per byte):
    - oPolyRdEn=1, oPolyAddr = 8*byte + bit counter; bit counter increments.
    - In every FETCH cycle except the first of a byte, capture the bit for the previous address.
    - After address 8*byte+7 is issued -> LAST.
  - LAST (1 cycle):
    - oPolyRdEn=0; capture bit 7 -> PUSH.
  - PUSH:
    - If !oMsgValid || iMsgReady: load oMsgByte from the shift register, set oMsgIdx=byte, set oMsgValid=1.
    - Then go to DONE if byte==31, else increment byte and go to FETCH.
    - Otherwise hold in PUSH; no reads are issued.
  - DONE:
    - oDone=1 for exactly 1 cycle -> IDLE.
    - oMsgValid for byte 31 may still be pending and stays held until accepted.
- Output register rules:
  - oMsgValid clears on a transfer unless PUSH loads a new byte in the same cycle, in which case valid stays 1 with the new data.
  - oMsgByte and oMsgIdx are stable while oMsgValid && !iMsgReady.
- Timing:
  - With iMsgReady tied to 1, throughput is 10 cycles per byte.
  - iStart sampled at cycle 0:
    - addresses 0..7 are issued in cycles 1..8;
    - LAST is cycle 9;
    - PUSH is cycle 10;
    - oMsgValid for byte 0 is first seen in cycle 11.
  - oDone is asserted in cycle 321.
- Mid-operation and idle conditions:
  - rst mid-operation aborts immediately: no oDone, oMsgValid drops, and the next iStart restarts from address 0.
  - A byte pending on the output in IDLE (byte 31 not yet accepted) does not block a new iStart. The new run stalls in PUSH until that byte is taken.
- Address range: oPolyAddr never exceeds KYBER_N-1. No address wrap within a run.

Test Plan:
- Boundary coefficients: coeffs[0..7] = 832, 833, 2496, 2497, 0, 3328, 1664, 4095 -> byte 0 = 0x46 (bits 1, 2 and 6 set).
- Full run with iMsgReady=1 and coeff[k] = (k odd) ? 1664 : 0:
  - 32 bytes, each 0xAA, with oMsgIdx 0..31 in order;
  - first oMsgValid in cycle 11, oDone in cycle 321;
  - oPolyAddr sequence 0..255 with no gaps or repeats.
- Backpressure: iMsgReady=0 for 50 cycles after byte 0 becomes valid:
  - byte 0 is held stable;
  - the FSM holds in PUSH after fetching byte 1, with no oPolyRdEn;
  - release -> byte 0 then byte 1 transfer; all 32 bytes are correct and none are lost or duplicated.
- Start handling: iStart pulsed while busy, and iStart held high for 3 cycles -> exactly one run (256 reads, one oDone).
- Reset mid-run: assert rst at byte 12 during FETCH ->
  - the next cycle has oBusy=0, oMsgValid=0, oPolyRdEn=0 and no oDone;
  - a new iStart produces a full correct 32-byte run from address 0.
- Back-to-back runs: hold iMsgReady=0 at the end of run 1, then issue iStart ->
  - run 2 fetches byte 0 then stalls until run 1 byte 31 is accepted;
  - the output ordering is run 1 byte 31, then run 2 byte 0.
